// File: rtl/otter_mem_port2_arbiter_if.sv
// Port-2 bus bundle: both requesters' command/response signals and the
// memory-side data port.  The arbiter takes the slave view; requesters and
// the memory take the master view.
interface otter_mem_port2_arbiter_if #(
    parameter int ADDR_W = 32
);
    // requester M0 (CPU data path)
    logic              M0_REQ;
    logic              M0_WE;
    logic [ADDR_W-1:0] M0_ADDR;
    logic [31:0]       M0_DIN;
    logic [1:0]        M0_SIZE;
    logic              M0_SIGN;
    logic              M0_GNT;
    logic              M0_DONE;
    logic [31:0]       M0_RDATA;
    logic              M0_ERR;

    // requester M1 (debug / program loader)
    logic              M1_REQ;
    logic              M1_WE;
    logic [ADDR_W-1:0] M1_ADDR;
    logic [31:0]       M1_DIN;
    logic [1:0]        M1_SIZE;
    logic              M1_SIGN;
    logic              M1_GNT;
    logic              M1_DONE;
    logic [31:0]       M1_RDATA;
    logic              M1_ERR;

    // memory data port
    logic [ADDR_W-1:0] MEM_ADDR2;
    logic [31:0]       MEM_DIN2;
    logic              MEM_WRITE2;
    logic              MEM_READ2;
    logic [1:0]        MEM_SIZE;
    logic              MEM_SIGN;
    logic [31:0]       MEM_DOUT2;
    logic              MEM_ERR;

    modport master (
        output M0_REQ, M0_WE, M0_ADDR, M0_DIN, M0_SIZE, M0_SIGN,
        input  M0_GNT, M0_DONE, M0_RDATA, M0_ERR,
        output M1_REQ, M1_WE, M1_ADDR, M1_DIN, M1_SIZE, M1_SIGN,
        input  M1_GNT, M1_DONE, M1_RDATA, M1_ERR,
        input  MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN,
        output MEM_DOUT2, MEM_ERR
    );

    modport slave (
        input  M0_REQ, M0_WE, M0_ADDR, M0_DIN, M0_SIZE, M0_SIGN,
        output M0_GNT, M0_DONE, M0_RDATA, M0_ERR,
        input  M1_REQ, M1_WE, M1_ADDR, M1_DIN, M1_SIZE, M1_SIGN,
        output M1_GNT, M1_DONE, M1_RDATA, M1_ERR,
        output MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN,
        input  MEM_DOUT2, MEM_ERR
    );
endinterface

// File: rtl/otter_mem_port2_arbiter.sv
// OTTER memory port-2 arbiter.  Shares the data port between the CPU (M0,
// default priority) and a debug/loader requester (M1).  Each access runs
// IDLE -> ISSUE (-> RESP for loads) -> IDLE; address/size/sign stay put
// through RESP because the memory slices load data from them
// combinationally.  A starvation counter lets M1 pre-empt M0 after
// MAX_WAIT consecutive denied cycles.  All memory-side outputs are registers.
module otter_mem_port2_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int ADDR_W   = 32
) (
    input logic                        MEM_CLK,
    input logic                        MEM_RST_N,
    otter_mem_port2_arbiter_if.slave   bus
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    state_t state, state_nxt;

    // arbitration / command select
    logic              gnt0, gnt1;
    logic              m1_starved;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_din;
    logic [1:0]        sel_size;
    logic              sel_sign;

    // latched command (drives the memory port directly)
    logic              owner_q;      // 0 = M0, 1 = M1
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              write_q;
    logic              read_q;
    logic              err_q;        // MEM_ERR sampled in ISSUE, for loads

    // starvation counter for M1
    logic [7:0]        wait_cnt;

    // per-requester completion registers
    logic              m0_done_q, m1_done_q;
    logic              m0_err_q,  m1_err_q;
    logic [31:0]       m0_rdata_q, m1_rdata_q;

    assign m1_starved = bus.M1_REQ && (wait_cnt == WAIT_LIMIT);

    // Next-state and grant decode; grants only in IDLE with reset released.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (MEM_RST_N) begin
                    if (m1_starved)
                        gnt1 = 1'b1;
                    else if (bus.M0_REQ)
                        gnt0 = 1'b1;
                    else if (bus.M1_REQ)
                        gnt1 = 1'b1;
                end
                if (gnt0 || gnt1)
                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE: state_nxt = we_q ? ST_IDLE : ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Command mux for the granted requester.
    always_comb begin
        sel_we   = gnt1 ? bus.M1_WE   : bus.M0_WE;
        sel_addr = gnt1 ? bus.M1_ADDR : bus.M0_ADDR;
        sel_din  = gnt1 ? bus.M1_DIN  : bus.M0_DIN;
        sel_size = gnt1 ? bus.M1_SIZE : bus.M0_SIZE;
        sel_sign = gnt1 ? bus.M1_SIGN : bus.M0_SIGN;
    end

    // State register.
    always_ff @(posedge MEM_CLK) begin
        if (!MEM_RST_N)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Latch the granted command; strobes last exactly the ISSUE cycle while
    // address/size/sign hold until the next grant.
    always_ff @(posedge MEM_CLK) begin
        if (!MEM_RST_N) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (gnt0 || gnt1) begin
            owner_q <= gnt1;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            din_q   <= sel_din;
            size_q  <= sel_size;
            sign_q  <= sel_sign;
            write_q <= sel_we;
            read_q  <= !sel_we;
        end else if (state == ST_ISSUE) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            err_q   <= bus.MEM_ERR;
        end
    end

    // Completion: stores finish out of ISSUE, loads out of RESP; DONE/ERR
    // are single-cycle pulses, RDATA holds for the non-owner.
    always_ff @(posedge MEM_CLK) begin
        if (!MEM_RST_N) begin
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
            if (state == ST_ISSUE && we_q) begin
                if (owner_q) begin
                    m1_done_q <= 1'b1;
                    m1_err_q  <= bus.MEM_ERR;
                end else begin
                    m0_done_q <= 1'b1;
                    m0_err_q  <= bus.MEM_ERR;
                end
            end else if (state == ST_RESP) begin
                if (owner_q) begin
                    m1_done_q  <= 1'b1;
                    m1_err_q   <= err_q;
                    m1_rdata_q <= bus.MEM_DOUT2;
                end else begin
                    m0_done_q  <= 1'b1;
                    m0_err_q   <= err_q;
                    m0_rdata_q <= bus.MEM_DOUT2;
                end
            end
        end
    end

    // M1 starvation counter: counts denied request cycles, saturating.
    always_ff @(posedge MEM_CLK) begin
        if (!MEM_RST_N)
            wait_cnt <= '0;
        else if (!bus.M1_REQ || gnt1)
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_LIMIT)
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign bus.M0_GNT     = gnt0;
    assign bus.M1_GNT     = gnt1;
    assign bus.M0_DONE    = m0_done_q;
    assign bus.M1_DONE    = m1_done_q;
    assign bus.M0_ERR     = m0_err_q;
    assign bus.M1_ERR     = m1_err_q;
    assign bus.M0_RDATA   = m0_rdata_q;
    assign bus.M1_RDATA   = m1_rdata_q;
    assign bus.MEM_ADDR2  = addr_q;
    assign bus.MEM_DIN2   = din_q;
    assign bus.MEM_WRITE2 = write_q;
    assign bus.MEM_READ2  = read_q;
    assign bus.MEM_SIZE   = size_q;
    assign bus.MEM_SIGN   = sign_q;

endmodule

// File: doc/otter_mem_port2_arbiter.md
Name: otter_mem_port2_arbiter

Overview:
Shares the data port (port 2) of the OTTER dual-port byte-addressable memory between two requesters: M0, the CPU data path (default priority), and M1, a debug/program loader. It sequences each access into issue/response phases. It also holds the address, size and sign stable through the read-data cycle, because the memory's load slicing depends combinationally on them. A starvation counter guarantees M1 forward progress. All memory-side outputs are registered.

Parameters:
MAX_WAIT, 8, number of consecutive cycles M1 may be denied while requesting before it takes priority over M0 (range 1..255).
ADDR_W, 32, width of the address buses.

Ports:
MEM_CLK  in  1  clock; all state changes on the rising edge
MEM_RST_N  in  1  synchronous, active-low reset
M0_REQ, M1_REQ  in  1  access request; held with its command until GNT
M0_WE, M1_WE  in  1  1 = store, 0 = load
M0_ADDR, M1_ADDR  in  ADDR_W  byte address
M0_DIN, M1_DIN  in  32  store data
M0_SIZE, M1_SIZE  in  2  0 = byte, 1 = half, 2 = word
M0_SIGN, M1_SIGN  in  1  1 = unsigned load (func3[2])
M0_GNT, M1_GNT  out  1  command accepted this cycle (combinational, IDLE only)
M0_DONE, M1_DONE  out  1  one-cycle completion pulse (registered)
M0_RDATA, M1_RDATA  out  32  load data; valid while the matching DONE is high for a load
M0_ERR, M1_ERR  out  1  memory ERR sampled during ISSUE; valid with DONE
MEM_ADDR2  out  ADDR_W  to memory
MEM_DIN2  out  32  to memory
MEM_WRITE2, MEM_READ2  out  1  to memory
MEM_SIZE  out  2  to memory
MEM_SIGN  out  1  to memory
MEM_DOUT2  in  32  sliced load data from memory, valid the cycle after MEM_READ2
MEM_ERR  in  1  memory misalign/out-of-range flag

Behaviour:
- Reset (MEM_RST_N = 0 at an edge):
  - State goes to IDLE; every output register is cleared: MEM_*, DONE, RDATA, ERR all 0; wait counter = 0; owner = M0.
  - GNT is 0 whenever the state is not IDLE or reset is low.
  - Reset mid-access drops the access: no DONE is issued. A MEM_WRITE2 already high in the reset cycle is still sampled by the memory on that edge.
- IDLE, arbitration:
  - If M1_REQ and wait counter == MAX_WAIT: select M1.
  - Else if M0_REQ: select M0.
  - Else if M1_REQ: select M1.
  - Selected GNT = 1 this cycle. The command is latched into the MEM_* registers and owner is recorded. Next state is ISSUE.
  - No request: stay in IDLE; MEM_READ2/MEM_WRITE2 = 0; address registers hold their last value.
- ISSUE (1 cycle):
  - MEM_WRITE2 = WE and MEM_READ2 = !WE, with the latched address/data/size/sign.
  - MEM_ERR is captured.
  - Store: next edge clears MEM_WRITE2, pulses owner DONE (with ERR) in the following cycle, next state IDLE.
  - Load: next state RESP.
- RESP (loads only, 1 cycle):
  - MEM_READ2 = 0; MEM_ADDR2/MEM_SIZE/MEM_SIGN are held unchanged.
  - MEM_DOUT2 is registered into the owner RDATA. Owner DONE pulses the next cycle (the cycle the FSM is back in IDLE). Next state IDLE.
- Latency from GNT cycle T: store DONE at T+2; load DONE and RDATA at T+3.
- Back-to-back: a new GNT may be given in the same IDLE cycle as the previous DONE. Peak throughput is one store per 2 cycles and one load per 3 cycles.
- RDATA of the non-owner holds its previous value. DONE and ERR are 0 outside the pulse.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle M1_REQ = 1 and M1_GNT = 0, including non-IDLE cycles.
  - Clears on M1_GNT or when M1_REQ = 0.
  - Cannot exceed MAX_WAIT.
- Simultaneous requests with counter < MAX_WAIT: M0 wins, M1 waits.
- IO-region addresses (>= 0x11000000) pass through unchanged. The memory handles IO_WR and the IO read buffer; the arbiter's sequencing is identical.
- A requester dropping REQ before GNT simply withdraws; no side effects.

Test Plan:
- Reset: hold MEM_RST_N = 0 for 3 cycles with M0_REQ = 1 -> GNT = 0, MEM_WRITE2 = MEM_READ2 = 0, DONE = 0. Release -> M0_GNT in the first IDLE cycle.
- M0 store: addr 0x100, din 0xDEADBEEF, size 2 -> MEM_WRITE2 = 1 for exactly one cycle at T+1, M0_DONE at T+2, ERR = 0. A subsequent M0 load of 0x100 -> M0_RDATA = 0xDEADBEEF with DONE at T+3, and MEM_ADDR2 held stable during RESP.
- Byte load sign: memory word 0x80FF0000 at 0x200. M0 lb 0x203 (sign 0, size 0) -> 0xFFFFFF80; lbu -> 0x00000080.
- Contention: M0_REQ and M1_REQ held high continuously, MAX_WAIT = 8 -> M1_GNT occurs once the counter reaches 8, then M0 is served next. M1 is never denied more than 8 + 3 cycles.
- Misaligned: M1 lw 0x102 -> M1_DONE with M1_ERR = 1 at T+3; M0 outputs are unaffected.
- Reset during RESP of an M1 load -> no M1_DONE pulse; the FSM is in IDLE the cycle after reset releases; counter = 0.
